// File: rtl/mem_dump_reader.sv
// mem_dump_reader: sweeps a range of addresses of a 1-cycle-latency memory and
// streams each word out on a valid/ready interface, tagged with its address.
//
// Ports:
//   clk, rst        clock and synchronous active-high reset
//   start           request a sweep (sampled only while idle)
//   base_addr       first address of the sweep (wraps modulo 2**AW)
//   count           number of words to read, 0..2**AW
//   busy            sweep in progress
//   done            one-cycle pulse after the final word is accepted
//   mem_we          memory write enable, tied low
//   mem_addr        memory read address
//   mem_dout        memory read data, valid one cycle after mem_addr is sampled
//   out_valid       output word available
//   out_ready       downstream accepts the word on valid && ready
//   out_data        word read from memory
//   out_addr        address the word came from
//   out_last        marks the final word of the sweep
module mem_dump_reader #(
  parameter int unsigned DW     = 32,
  parameter int unsigned AW     = 5,
  parameter int unsigned RD_LAT = 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic [AW-1:0] base_addr,
  input  logic [AW:0]   count,
  output logic          busy,
  output logic          done,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  input  logic [DW-1:0] mem_dout,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [DW-1:0] out_data,
  output logic [AW-1:0] out_addr,
  output logic          out_last
);

  // Only a single-cycle read latency is handled; any other value disables capture.
  localparam bit LatSupported = (RD_LAT == 1);

  typedef enum logic [1:0] {StIdle, StRun, StDrain} state_e;

  state_e        state_q;
  logic [AW:0]   left_q;        // reads still to be issued
  logic          busy_q;
  logic          done_q;
  logic [AW-1:0] mem_addr_q;    // address the memory samples on the next issue

  // One read may be in flight; its tag travels alongside until capture.
  logic          inflight_q;
  logic [AW-1:0] inflight_addr_q;
  logic          inflight_last_q;

  // Two-entry output FIFO.
  logic [DW-1:0] fifo_data_q [2];
  logic [AW-1:0] fifo_addr_q [2];
  logic          fifo_last_q [2];
  logic          rd_ptr_q;
  logic          wr_ptr_q;
  logic [1:0]    occ_q;

  logic          pop;
  logic          push;
  logic          issue;
  logic [2:0]    used;

  always_comb begin
    pop   = (occ_q != 2'd0) && out_ready;
    push  = inflight_q && LatSupported;
    // A word leaving this cycle frees its slot, so steady streaming keeps one
    // word buffered and one in flight.
    used  = {1'b0, occ_q} + {2'b0, inflight_q} - {2'b0, pop};
    issue = (state_q == StRun) && (left_q != '0) && (used < 3'd2);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q         <= StIdle;
      left_q          <= '0;
      busy_q          <= 1'b0;
      done_q          <= 1'b0;
      mem_addr_q      <= '0;
      inflight_q      <= 1'b0;
      inflight_addr_q <= '0;
      inflight_last_q <= 1'b0;
      rd_ptr_q        <= 1'b0;
      wr_ptr_q        <= 1'b0;
      occ_q           <= 2'd0;
      for (int i = 0; i < 2; i++) begin
        fifo_data_q[i] <= '0;
        fifo_addr_q[i] <= '0;
        fifo_last_q[i] <= 1'b0;
      end
    end else begin
      done_q     <= 1'b0;
      inflight_q <= issue;

      if (issue) begin
        inflight_addr_q <= mem_addr_q;
        inflight_last_q <= (left_q == (AW+1)'(1));
        mem_addr_q      <= mem_addr_q + AW'(1);
        left_q          <= left_q - (AW+1)'(1);
      end

      if (push) begin
        fifo_data_q[wr_ptr_q] <= mem_dout;
        fifo_addr_q[wr_ptr_q] <= inflight_addr_q;
        fifo_last_q[wr_ptr_q] <= inflight_last_q;
        wr_ptr_q              <= ~wr_ptr_q;
      end
      if (pop) begin
        rd_ptr_q <= ~rd_ptr_q;
      end
      occ_q <= occ_q + 2'(push) - 2'(pop);

      unique case (state_q)
        StIdle: begin
          if (start) begin
            if (count != '0) begin
              mem_addr_q <= base_addr;
              left_q     <= count;
              busy_q     <= 1'b1;
              state_q    <= StRun;
            end else begin
              done_q <= 1'b1;
            end
          end
        end
        StRun: begin
          if (issue && (left_q == (AW+1)'(1))) begin
            state_q <= StDrain;
          end
        end
        StDrain: begin
          // Order is preserved, so the last-tagged word leaving means the
          // buffer is empty and nothing remains in flight.
          if (pop && fifo_last_q[rd_ptr_q]) begin
            done_q  <= 1'b1;
            busy_q  <= 1'b0;
            state_q <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign mem_we    = 1'b0;
  assign mem_addr  = mem_addr_q;
  assign out_valid = (occ_q != 2'd0);
  assign out_data  = fifo_data_q[rd_ptr_q];
  assign out_addr  = fifo_addr_q[rd_ptr_q];
  assign out_last  = fifo_last_q[rd_ptr_q];

endmodule

// File: tb/tb_mem_dump_reader.sv
module tb_mem_dump_reader;

  logic        clk;
  logic        rst;
  logic        start;
  logic [4:0]  base_addr;
  logic [5:0]  count;
  logic        busy;
  logic        done;
  logic        mem_we;
  logic [4:0]  mem_addr;
  logic [31:0] mem_dout;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;
  logic [4:0]  out_addr;
  logic        out_last;

  int errors = 0;
  int checks = 0;
  int done_cnt = 0;
  int we_cnt = 0;

  logic [31:0] mem [32];

  mem_dump_reader #(.DW(32), .AW(5), .RD_LAT(1)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .base_addr (base_addr),
    .count     (count),
    .busy      (busy),
    .done      (done),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_dout  (mem_dout),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_addr  (out_addr),
    .out_last  (out_last)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory with registered read, preloaded with A000_0000 + index.
  initial begin
    for (int i = 0; i < 32; i++) mem[i] = 32'hA000_0000 + 32'(i);
  end
  always @(posedge clk) mem_dout <= mem[mem_addr];

  always @(posedge clk) begin
    if (done) done_cnt <= done_cnt + 1;
    if (mem_we) we_cnt <= we_cnt + 1;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Runs one sweep. pat 0: out_ready always high; pat 1: ready 1-0-0-1-0-1 repeating.
  // restart_at >= 0 pulses a second start at that cycle; abort_after > 0 stops
  // collecting after that many words (the caller then resets).
  task automatic sweep(input string tag, input logic [4:0] b, input int n, input int pat,
                       input int restart_at, input int abort_after);
    int          k;
    int          cyc;
    int          first_cyc;
    int          last_cyc;
    int          dc0;
    logic        held;
    logic [31:0] hd;
    logic [4:0]  ha;
    logic        hl;
    logic [4:0]  ea;
    logic [5:0]  pbits;
    pbits = 6'b101001;
    dc0 = done_cnt;
    k = 0; cyc = 0; held = 1'b0; first_cyc = -1; last_cyc = -1;
    start = 1'b1; base_addr = b; count = 6'(n);
    tick();
    start = 1'b0;
    check({tag, " busy after start"}, 64'(busy), 64'(1));
    check({tag, " mem_addr=base"}, 64'(mem_addr), 64'(b));
    while (k < n && cyc < 400) begin
      if (abort_after > 0 && k == abort_after) break;
      start = (cyc == restart_at);
      base_addr = 5'd10;
      count = 6'd5;
      out_ready = (pat == 0) ? 1'b1 : pbits[cyc % 6];
      if (out_valid) begin
        if (held) begin
          check({tag, " held data"}, 64'(out_data), 64'(hd));
          check({tag, " held addr"}, 64'(out_addr), 64'(ha));
          check({tag, " held last"}, 64'(out_last), 64'(hl));
        end
        if (out_ready) begin
          ea = b + 5'(k);
          check({tag, " addr"}, 64'(out_addr), 64'(ea));
          check({tag, " data"}, 64'(out_data), 64'(32'hA000_0000 + 32'(ea)));
          check({tag, " last"}, 64'(out_last), 64'(k == n - 1));
          if (first_cyc < 0) first_cyc = cyc;
          last_cyc = cyc;
          k++;
          held = 1'b0;
        end else begin
          held = 1'b1; hd = out_data; ha = out_addr; hl = out_last;
        end
      end
      tick();
      cyc++;
    end
    start = 1'b0;
    if (abort_after > 0) return;
    check({tag, " word count"}, 64'(k), 64'(n));
    check({tag, " done after last"}, 64'(done), 64'(1));
    check({tag, " busy clear with done"}, 64'(busy), 64'(0));
    check({tag, " valid clear"}, 64'(out_valid), 64'(0));
    if (pat == 0) begin
      check({tag, " first valid cycle"}, 64'(first_cyc), 64'(2));
      check({tag, " back-to-back"}, 64'(last_cyc - first_cyc), 64'(n - 1));
    end
    out_ready = 1'b1;
    tick();
    check({tag, " done is a pulse"}, 64'(done), 64'(0));
    check({tag, " single done"}, 64'(done_cnt - dc0), 64'(1));
  endtask

  initial begin
    int dc;
    rst = 1'b1; start = 1'b0; base_addr = '0; count = '0; out_ready = 1'b1;
    tick();
    tick();
    check("reset busy", 64'(busy), 64'(0));
    check("reset done", 64'(done), 64'(0));
    check("reset mem_addr", 64'(mem_addr), 64'(0));
    check("reset valid", 64'(out_valid), 64'(0));
    check("reset data", 64'(out_data), 64'(0));
    check("reset addr", 64'(out_addr), 64'(0));
    check("reset last", 64'(out_last), 64'(0));
    rst = 1'b0;
    tick();

    sweep("base0", 5'd0, 4, 0, -1, 0);
    sweep("wrap30", 5'd30, 4, 0, -1, 0);
    sweep("throttle", 5'd5, 6, 1, -1, 0);

    // Zero-length request.
    dc = done_cnt;
    start = 1'b1; base_addr = 5'd7; count = 6'd0;
    tick();
    start = 1'b0;
    check("cnt0 done", 64'(done), 64'(1));
    check("cnt0 busy", 64'(busy), 64'(0));
    check("cnt0 valid", 64'(out_valid), 64'(0));
    tick();
    check("cnt0 done pulse", 64'(done), 64'(0));
    check("cnt0 valid later", 64'(out_valid), 64'(0));
    tick();
    check("cnt0 single done", 64'(done_cnt - dc), 64'(1));

    sweep("full32", 5'd0, 32, 0, 5, 0);
    check("full32 no restart", 64'(out_valid | busy), 64'(0));

    // Reset in the middle of a sweep.
    dc = done_cnt;
    sweep("abort", 5'd12, 8, 0, -1, 3);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("abort busy", 64'(busy), 64'(0));
    check("abort done", 64'(done), 64'(0));
    check("abort valid", 64'(out_valid), 64'(0));
    check("abort data", 64'(out_data), 64'(0));
    check("abort addr", 64'(out_addr), 64'(0));
    check("abort last", 64'(out_last), 64'(0));
    check("abort mem_addr", 64'(mem_addr), 64'(0));
    tick();
    tick();
    check("abort no done", 64'(done_cnt - dc), 64'(0));
    sweep("after abort", 5'd2, 2, 0, -1, 0);

    check("mem_we never high", 64'(we_cnt), 64'(0));
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
